// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - width encodings, FSM state codes and protection defaults for the load/store unit
package lsu_pkg;

    localparam logic [2:0] WIDTH_B  = 3'b000;
    localparam logic [2:0] WIDTH_H  = 3'b001;
    localparam logic [2:0] WIDTH_W  = 3'b010;
    localparam logic [2:0] WIDTH_BU = 3'b100;
    localparam logic [2:0] WIDTH_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC0 = 2'd1;
    localparam logic [1:0] ST_ACC1 = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [31:0] PROT_BASE_DEFAULT  = 32'h0000_0060;
    localparam logic [31:0] PROT_LIMIT_DEFAULT = 32'h0000_007F;

    function automatic logic width_legal(input logic [2:0] width);
        return (width == WIDTH_B) || (width == WIDTH_H) || (width == WIDTH_W) ||
               (width == WIDTH_BU) || (width == WIDTH_HU);
    endfunction

    // Byte mask of the access before lane positioning; zero for illegal codes.
    function automatic logic [3:0] width_mask(input logic [2:0] width);
        case (width)
            WIDTH_B, WIDTH_BU: return 4'b0001;
            WIDTH_H, WIDTH_HU: return 4'b0011;
            WIDTH_W:           return 4'b1111;
            default:           return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] width_size(input logic [2:0] width);
        case (width)
            WIDTH_B, WIDTH_BU: return 3'd1;
            WIDTH_H, WIDTH_HU: return 3'd2;
            WIDTH_W:           return 3'd4;
            default:           return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane shifting, byte enables and little-endian merge/extend for both access halves
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  width,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] rdata_ext
);

    logic [3:0]  mask;
    logic [7:0]  be_wide;
    logic [4:0]  lo_shift;
    logic [5:0]  hi_shift;
    logic [31:0] merged;

    always_comb begin
        mask     = width_mask(width);
        lo_shift = {offset, 3'b000};
        // Second-half shift is 32 when offset is 0, which cleanly yields zero.
        hi_shift = 6'd32 - {1'b0, lo_shift};
        be_wide  = {4'b0000, mask} << offset;
        be_lo    = be_wide[3:0];
        be_hi    = mask >> (3'd4 - {1'b0, offset});
        wdata_lo = wdata << lo_shift;
        wdata_hi = wdata >> hi_shift;
        merged   = (rdata_lo >> lo_shift) | (rdata_hi << hi_shift);
        case (width)
            WIDTH_B:  rdata_ext = {{24{merged[7]}}, merged[7:0]};
            WIDTH_BU: rdata_ext = {24'h0, merged[7:0]};
            WIDTH_H:  rdata_ext = {{16{merged[15]}}, merged[15:0]};
            WIDTH_HU: rdata_ext = {16'h0, merged[15:0]};
            WIDTH_W:  rdata_ext = merged;
            default:  rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit with split unaligned accesses and a lockable store-protected region
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [31:0] PROT_BASE  = PROT_BASE_DEFAULT,
    parameter logic [31:0] PROT_LIMIT = PROT_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        lock_write,
    input  logic        lock_wdata,
    output logic        lock_status
);

    logic [1:0]  state;
    logic [2:0]  width_q;
    logic        write_q;
    logic [29:0] word_q;
    logic [31:0] wdata_q;
    logic [1:0]  offset_q;
    logic        split_q;
    logic        fault_q;
    logic [31:0] rdata0_q;
    logic        lock_q;

    logic        accept;
    logic        req_legal;
    logic [2:0]  req_size;
    logic        req_split;
    logic        prot_hit;
    logic [31:0] byte_addr;
    logic        in_acc;
    logic [31:0] acc0_addr;

    logic [3:0]  be_lo, be_hi;
    logic [31:0] wdata_lo, wdata_hi, rdata_lo, rdata_ext;

    assign req_ready   = (state == ST_IDLE) && !reset;
    assign accept      = req_valid && req_ready;
    assign req_legal   = width_legal(req_width);
    assign req_size    = width_size(req_width);
    assign req_split   = req_legal && (({1'b0, req_addr[1:0]} + req_size) > 3'd4);
    assign lock_status = lock_q;

    // Byte addresses wrap mod 2^32, matching the second-half address wrap.
    always_comb begin
        prot_hit  = 1'b0;
        byte_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            byte_addr = req_addr + 32'(i);
            if ((3'(i) < req_size) && (byte_addr >= PROT_BASE) && (byte_addr <= PROT_LIMIT))
                prot_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 1'b1;
        end else if (lock_write) begin
            lock_q <= lock_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) state <= req_legal ? ST_ACC0 : ST_RESP;
                ST_ACC0: state <= split_q ? ST_ACC1 : ST_RESP;
                ST_ACC1: state <= ST_RESP;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Access decisions are frozen at acceptance; later lock writes do not affect them.
    always_ff @(posedge clk) begin
        if (accept) begin
            width_q  <= req_width;
            write_q  <= req_write;
            word_q   <= req_addr[31:2];
            wdata_q  <= req_wdata;
            offset_q <= req_addr[1:0];
            split_q  <= req_split;
            fault_q  <= !req_legal || (req_write && lock_q && prot_hit);
        end
        if (state == ST_ACC0) begin
            rdata0_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= 32'h0;
        end else begin
            resp_valid <= 1'b0;
            if (accept && !req_legal) begin
                resp_valid <= 1'b1;
                resp_fault <= 1'b1;
                resp_rdata <= 32'h0;
            end else if ((state == ST_ACC0 && !split_q) || state == ST_ACC1) begin
                resp_valid <= 1'b1;
                resp_fault <= fault_q;
                resp_rdata <= (write_q || fault_q) ? 32'h0 : rdata_ext;
            end
        end
    end

    assign rdata_lo = (state == ST_ACC1) ? rdata0_q : mem_rdata;

    lsu_align u_align (
        .width     (width_q),
        .offset    (offset_q),
        .wdata     (wdata_q),
        .rdata_lo  (rdata_lo),
        .rdata_hi  (mem_rdata),
        .be_lo     (be_lo),
        .be_hi     (be_hi),
        .wdata_lo  (wdata_lo),
        .wdata_hi  (wdata_hi),
        .rdata_ext (rdata_ext)
    );

    // Gating with reset keeps an aborted second half from ever writing.
    assign in_acc    = ((state == ST_ACC0) || (state == ST_ACC1)) && !reset;
    assign acc0_addr = {word_q, 2'b00};
    assign mem_en    = in_acc;
    assign mem_we    = in_acc && write_q && !fault_q;
    assign mem_addr  = (state == ST_ACC1) ? acc0_addr + 32'd4 : acc0_addr;
    assign mem_be    = !in_acc ? 4'b0000 : ((state == ST_ACC1) ? be_hi : be_lo);
    assign mem_wdata = !in_acc ? 32'h0 : ((state == ST_ACC1) ? wdata_hi : wdata_lo);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        lock_write, lock_wdata, lock_status;

    logic [31:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_width  (req_width),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .lock_write (lock_write),
        .lock_wdata (lock_wdata),
        .lock_status(lock_status)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int en_total = 0, we_total = 0, resp_total = 0, resp_cyc = 0;
    logic [31:0] log_addr [0:255];
    logic [31:0] log_wdata [0:255];
    logic [3:0]  log_be [0:255];
    logic [31:0] last_rdata;
    logic        last_fault;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_en) begin
            log_addr[en_total % 256]  = mem_addr;
            log_wdata[en_total % 256] = mem_wdata;
            log_be[en_total % 256]    = mem_be;
            en_total++;
        end
        if (mem_we) we_total++;
        if (resp_valid) begin
            resp_total++;
            resp_cyc   = cyc;
            last_rdata = resp_rdata;
            last_fault = resp_fault;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int r_lat, r_en, r_we, r_first;

    // Issues one request; response fields land in last_rdata/last_fault.
    task automatic access(input string tag, input logic wr, input logic [2:0] w,
                          input logic [31:0] a, input logic [31:0] d);
        int acc_c, r0, k;
        @(negedge clk);
        #1;
        req_valid = 1'b1; req_write = wr; req_width = w; req_addr = a; req_wdata = d;
        r_first = en_total;
        r_we    = we_total;
        r_0_snap: r0 = resp_total;
        k = 0;
        while (!req_ready && k < 10) begin @(negedge clk); #1; k++; end
        acc_c = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        while (resp_total == r0 && k < 10) begin @(negedge clk); #1; k++; end
        check({tag, "_resp"}, 32'(resp_total != r0), 32'd1);
        r_lat = resp_cyc - acc_c;
        r_en  = en_total - r_first;
        r_we  = we_total - r_we;
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_width = 3'b010;
        req_addr = 32'h0; req_wdata = 32'h0; lock_write = 1'b0; lock_wdata = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        check("rst_lock", 32'(lock_status), 32'd1);
        reset = 1'b0;
        #1 check("post_rst_ready", 32'(req_ready), 32'd1);

        access("lw10", 1'b0, 3'b010, 32'h10, 32'h0);
        check("lw10_rdata", last_rdata, 32'h8899AABB);
        check("lw10_fault", 32'(last_fault), 32'd0);
        check("lw10_lat", 32'(r_lat), 32'd2);
        check("lw10_en", 32'(r_en), 32'd1);
        check("lw10_be", 32'(log_be[r_first % 256]), 32'hF);

        access("lbu11", 1'b0, 3'b100, 32'h11, 32'h0);
        check("lbu11_rdata", last_rdata, 32'h000000AA);
        access("lb11", 1'b0, 3'b000, 32'h11, 32'h0);
        check("lb11_rdata", last_rdata, 32'hFFFFFFAA);
        access("lhu12", 1'b0, 3'b101, 32'h12, 32'h0);
        check("lhu12_rdata", last_rdata, 32'h00008899);
        access("lh12", 1'b0, 3'b001, 32'h12, 32'h0);
        check("lh12_rdata", last_rdata, 32'hFFFF8899);

        mem[4] = 32'h80112233;
        mem[5] = 32'h445566FF;
        access("lh13", 1'b0, 3'b001, 32'h13, 32'h0);
        check("lh13_rdata", last_rdata, 32'hFFFFFF80);
        check("lh13_lat", 32'(r_lat), 32'd3);
        check("lh13_en", 32'(r_en), 32'd2);

        access("sw0e", 1'b1, 3'b010, 32'h0E, 32'hDEADBEEF);
        check("sw0e_fault", 32'(last_fault), 32'd0);
        check("sw0e_rdata", last_rdata, 32'h0);
        check("sw0e_we", 32'(r_we), 32'd2);
        check("sw0e_a0", log_addr[r_first % 256], 32'h0C);
        check("sw0e_be0", 32'(log_be[r_first % 256]), 32'hC);
        check("sw0e_d0", log_wdata[r_first % 256], 32'hBEEF0000);
        check("sw0e_a1", log_addr[(r_first + 1) % 256], 32'h10);
        check("sw0e_be1", 32'(log_be[(r_first + 1) % 256]), 32'h3);
        check("sw0e_d1", log_wdata[(r_first + 1) % 256], 32'h0000DEAD);

        access("sb64_lk", 1'b1, 3'b000, 32'h64, 32'h000000AB);
        check("sb64_lk_fault", 32'(last_fault), 32'd1);
        check("sb64_lk_we", 32'(r_we), 32'd0);
        check("sb64_lk_en", 32'(r_en), 32'd1);
        access("sw5e_lk", 1'b1, 3'b010, 32'h5E, 32'h12345678);
        check("sw5e_lk_fault", 32'(last_fault), 32'd1);
        check("sw5e_lk_en", 32'(r_en), 32'd2);
        check("sw5e_lk_we", 32'(r_we), 32'd0);
        access("sb7f_lk", 1'b1, 3'b000, 32'h7F, 32'h11);
        check("sb7f_lk_fault", 32'(last_fault), 32'd1);
        access("sb80_lk", 1'b1, 3'b000, 32'h80, 32'h11);
        check("sb80_lk_fault", 32'(last_fault), 32'd0);
        check("sb80_lk_we", 32'(r_we), 32'd1);
        access("lw60_lk", 1'b0, 3'b010, 32'h60, 32'h0);
        check("lw60_lk_fault", 32'(last_fault), 32'd0);

        @(negedge clk);
        lock_write = 1'b1; lock_wdata = 1'b0;
        @(negedge clk);
        lock_write = 1'b0;
        check("unlock_status", 32'(lock_status), 32'd0);
        access("sb64", 1'b1, 3'b000, 32'h64, 32'h000000AB);
        check("sb64_fault", 32'(last_fault), 32'd0);
        check("sb64_we", 32'(r_we), 32'd1);
        check("sb64_be", 32'(log_be[r_first % 256]), 32'h1);
        check("sb64_addr", log_addr[r_first % 256], 32'h64);
        check("sb64_wdata", log_wdata[r_first % 256], 32'h000000AB);

        mem[63] = 32'h11223344;
        mem[0]  = 32'h55667788;
        access("lwwrap", 1'b0, 3'b010, 32'hFFFF_FFFD, 32'h0);
        check("lwwrap_a0", log_addr[r_first % 256], 32'hFFFF_FFFC);
        check("lwwrap_a1", log_addr[(r_first + 1) % 256], 32'h0);
        check("lwwrap_rdata", last_rdata, 32'h88112233);
        check("lwwrap_lat", 32'(r_lat), 32'd3);

        access("ill011", 1'b0, 3'b011, 32'h10, 32'h0);
        check("ill011_fault", 32'(last_fault), 32'd1);
        check("ill011_en", 32'(r_en), 32'd0);
        check("ill011_rdata", last_rdata, 32'h0);
        check("ill011_lat", 32'(r_lat), 32'd1);

        begin
            int w0, r0;
            @(negedge clk);
            #1;
            req_valid = 1'b1; req_write = 1'b1; req_width = 3'b010;
            req_addr = 32'h0E; req_wdata = 32'hDEADBEEF;
            w0 = we_total;
            r0 = resp_total;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1; lock_write = 1'b1; lock_wdata = 1'b0;
            @(negedge clk);
            #1;
            check("abort_mem_we", 32'(mem_we), 32'd0);
            check("abort_mem_en", 32'(mem_en), 32'd0);
            check("abort_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1 reset = 1'b0; lock_write = 1'b0;
            @(negedge clk);
            #1;
            check("abort_idle_ready", 32'(req_ready), 32'd1);
            check("abort_lock", 32'(lock_status), 32'd1);
            check("abort_writes", 32'(we_total - w0), 32'd1);
            check("abort_no_resp", 32'(resp_total - r0), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
